fwd_ctrl: RTL
=============

// Module: fwd_ctrl
// PURPOSE
//  Forwarding/hazard controller for the integer pipeline; drives the 2-bit selects of the EX-stage
//  operand mux3 instances (s=00 regfile, s=10 MEM result, s=11 WB result; s=01 never driven).
//  Tracks destination regs of instructions in EX and MEM, registers the selects on ID->EX advance,
//  and raises a load-use stall that inserts one EX bubble.
// PARAMETERS
//  REG_W       5  register index width
//  ZERO_REG    1  1: reg index 0 is hardwired zero, never matches a forward/stall
// PORTS
//  clk          in   1      clock, all state on rising edge
//  rst_n        in   1      asynchronous active-low reset
//  id_valid     in   1      valid instruction in ID
//  id_rs1/id_rs2 in  REG_W  source regs of ID instruction
//  id_use_rs1/2 in   1      source actually read (suppresses false hazards)
//  id_rd        in   REG_W  destination reg of ID instruction
//  id_we        in   1      ID instruction writes id_rd
//  id_is_load   in   1      ID instruction is a load (result ready only at WB)
//  hold         in   1      global pipeline freeze (e.g. cache miss)
//  flush        in   1      kill instruction in ID (taken branch/jump)
//  load_use_stall out 1     combinational; ID/IF must hold this cycle
//  fwd_a_sel    out  2      registered select for EX operand A mux3
//  fwd_b_sel    out  2      registered select for EX operand B mux3
//  stall_cnt    out  32     load-use stall count (only with FWD_STALL_CNT_EN)
// BEHAVIOUR
//  - State: ex_{v,rd,we,ld}, mem_{v,rd,we}, fwd_a_sel, fwd_b_sel. Reset: all 0, selects 2'b00.
//  - match(e,r,use) = e.v & e.we & use & (r==e.rd) & !(ZERO_REG & r==0).
//  - load_use_stall = id_valid & match(ex,rs1,use1)|match(ex,rs2,use2) with ex_ld; 0-cycle latency,
//    asserted even while hold (consumer must ignore under hold).
//  - Advance priority per edge: hold > flush > load_use_stall > normal.
//    hold:   every register keeps value.
//    flush:  mem<=ex; ex<=bubble (v=0); selects<=00.
//    stall:  mem<=ex; ex<=bubble; selects<=00 (ID instruction re-presented next cycle).
//    normal: mem<=ex; ex<=ID fields, v=id_valid; sel per operand:
//            match(ex,rs,use) -> 2'b10 (EX becomes MEM, youngest wins);
//            else match(mem,rs,use) -> 2'b11 (MEM becomes WB); else 2'b00.
//  - Selects are valid for the whole cycle the instruction sits in EX; 1-cycle latency from ID.
//  - id_valid=0 in normal advance loads a bubble; its selects forced to 00.
//  - After a load-use stall the load is in MEM: re-presented ID instruction gets 2'b11 (WB).
//  - rst_n asserted mid-operation: all state cleared immediately, no outputs glitch to 2'b01.
// CONFIGURATION
//  FWD_STALL_CNT_EN defined: 32-bit stall_cnt increments on each edge with load_use_stall & !hold,
//    saturates at 32'hFFFF_FFFF, reset to 0.
//  Not defined: stall_cnt port tied to 32'd0, no counter flop.
// STRUCTURE
//  Package fwd_pkg: typedef fwd_sel_e {FWD_RF=2'b00, FWD_MEM=2'b10, FWD_WB=2'b11};
//    typedef struct stage_tag_t {v, rd, we, ld}; REG_W default constant.
//  One sub-module: fwd_match (combinational match() for one source vs one stage tag), 6 instances.
// TESTING
//  1 add x5 then add x6,x5,x5 back-to-back -> next cycle fwd_a_sel=fwd_b_sel=2'b10, no stall.
//  2 add x5; nop; sub x7,x5,x1 -> fwd_a_sel=2'b11, fwd_b_sel=2'b00.
//  3 lw x8; add x9,x8,x2 -> load_use_stall=1 one cycle, bubble (sel 00), then fwd_a_sel=2'b11.
//  4 add x0 then add x3,x0,x0 with ZERO_REG=1 -> selects 00; ZERO_REG=0 -> 2'b10.
//  5 lw x4 in EX, ID uses x4 with flush=1 -> no stall effect, EX bubble, sel 00; hold=1 same cycle
//    -> all state frozen, stall_cnt unchanged.
//  6 rst_n low mid-stream with selects 2'b10 -> selects 00 and stall_cnt 0 immediately.

Source files
------------

// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared types and constants for the EX-stage forwarding controller
package fwd_pkg;

  localparam int FWD_REG_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic                 v;
    logic [FWD_REG_W-1:0] rd;
    logic                 we;
    logic                 ld;
  } stage_tag_t;

  localparam stage_tag_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/fwd_match.sv
// rtl/fwd_match.sv - compares one source register against one pipeline stage destination
module fwd_match
  import fwd_pkg::*;
#(
  parameter int REG_W    = FWD_REG_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             v,
  input  logic             we,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rs,
  input  logic             use_src,
  output logic             hit
);

  // a hardwired-zero source never depends on an older instruction
  always_comb begin
    hit = v & we & use_src & (rs == rd) & ~(ZERO_REG & (rs == '0));
  end

endmodule

// File: rtl/fwd_ctrl.sv
// rtl/fwd_ctrl.sv - forwarding select and load-use stall controller (optional FWD_STALL_CNT_EN stall counter)
module fwd_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_W    = FWD_REG_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             hold,
  input  logic             flush,
  output logic             load_use_stall,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [31:0]      stall_cnt
);

  // stage tags carry FWD_REG_W index bits; REG_W is expected not to exceed that
  localparam int TW = FWD_REG_W;

  stage_tag_t ex_q, mem_q, id_tag;
  fwd_sel_e   sel_a_q, sel_b_q, sel_a_d, sel_b_d;
  logic [TW-1:0] rs1_t, rs2_t;
  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, lu_hit_a, lu_hit_b;
  logic unused_mem_ld;

  assign rs1_t = TW'(id_rs1);
  assign rs2_t = TW'(id_rs2);

  // the MEM copy of the load flag is carried only so the tag type stays uniform
  assign unused_mem_ld = mem_q.ld;

  // pack the ID instruction into the tag that will occupy EX
  always_comb begin
    id_tag    = STAGE_BUBBLE;
    id_tag.v  = id_valid;
    id_tag.rd = TW'(id_rd);
    id_tag.we = id_we;
    id_tag.ld = id_is_load;
  end

  fwd_match #(.REG_W(TW), .ZERO_REG(ZERO_REG)) u_ex_a (
    .v(ex_q.v), .we(ex_q.we), .rd(ex_q.rd), .rs(rs1_t), .use_src(id_use_rs1), .hit(ex_hit_a));
  fwd_match #(.REG_W(TW), .ZERO_REG(ZERO_REG)) u_ex_b (
    .v(ex_q.v), .we(ex_q.we), .rd(ex_q.rd), .rs(rs2_t), .use_src(id_use_rs2), .hit(ex_hit_b));
  fwd_match #(.REG_W(TW), .ZERO_REG(ZERO_REG)) u_mem_a (
    .v(mem_q.v), .we(mem_q.we), .rd(mem_q.rd), .rs(rs1_t), .use_src(id_use_rs1), .hit(mem_hit_a));
  fwd_match #(.REG_W(TW), .ZERO_REG(ZERO_REG)) u_mem_b (
    .v(mem_q.v), .we(mem_q.we), .rd(mem_q.rd), .rs(rs2_t), .use_src(id_use_rs2), .hit(mem_hit_b));
  // load-use compares only against a load in EX, so the write-enable is qualified by ld
  fwd_match #(.REG_W(TW), .ZERO_REG(ZERO_REG)) u_lu_a (
    .v(ex_q.v), .we(ex_q.we & ex_q.ld), .rd(ex_q.rd), .rs(rs1_t), .use_src(id_use_rs1), .hit(lu_hit_a));
  fwd_match #(.REG_W(TW), .ZERO_REG(ZERO_REG)) u_lu_b (
    .v(ex_q.v), .we(ex_q.we & ex_q.ld), .rd(ex_q.rd), .rs(rs2_t), .use_src(id_use_rs2), .hit(lu_hit_b));

  // stall is raised regardless of hold/flush; the consumer decides whether it matters
  always_comb begin
    load_use_stall = id_valid & (lu_hit_a | lu_hit_b);
  end

  // youngest producer wins: EX result (arriving from MEM) before MEM result (arriving from WB)
  always_comb begin
    sel_a_d = FWD_RF;
    sel_b_d = FWD_RF;
    if (id_valid) begin
      if (ex_hit_a)       sel_a_d = FWD_MEM;
      else if (mem_hit_a) sel_a_d = FWD_WB;
      if (ex_hit_b)       sel_b_d = FWD_MEM;
      else if (mem_hit_b) sel_b_d = FWD_WB;
    end
  end

  // pipeline advance: hold freezes everything, flush/stall inject an EX bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= STAGE_BUBBLE;
      mem_q   <= STAGE_BUBBLE;
      sel_a_q <= FWD_RF;
      sel_b_q <= FWD_RF;
    end else if (!hold) begin
      mem_q <= ex_q;
      if (flush || load_use_stall) begin
        ex_q    <= STAGE_BUBBLE;
        sel_a_q <= FWD_RF;
        sel_b_q <= FWD_RF;
      end else begin
        ex_q    <= id_tag;
        sel_a_q <= sel_a_d;
        sel_b_q <= sel_b_d;
      end
    end
  end

  assign fwd_a_sel = sel_a_q;
  assign fwd_b_sel = sel_b_q;

`ifdef FWD_STALL_CNT_EN
  logic [31:0] cnt_q;

  // count cycles actually lost to load-use, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_use_stall && !hold && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule
